// File: rtl/muldiv_seq_pkg.sv
// Shared decode constants, op and FSM state types for the sequential multiply/divide unit.
package muldiv_seq_pkg;

  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic       FNC7_MULDIV   = 1'b1;

  typedef enum logic [2:0] {
    FNC_MUL    = 3'b000,
    FNC_MULH   = 3'b001,
    FNC_MULHSU = 3'b010,
    FNC_MULHU  = 3'b011,
    FNC_DIV    = 3'b100,
    FNC_DIVU   = 3'b101,
    FNC_REM    = 3'b110,
    FNC_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  function automatic logic decode_muldiv(input logic [6:0] opcode, input logic funct7_m);
    return (opcode == OPC_ARI_RTYPE) && (funct7_m == FNC7_MULDIV);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Operand/op request and result handshake bundle between the execute stage and muldiv_seq.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_m;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, opcode, funct3, funct7_m, rs1, rs2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7_m, rs1, rs2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_seq_step.sv
// One radix-2 step: shift-add for multiply (LSB-first), restoring subtract for divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] opb,
  input  logic [XLEN:0]   acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  output logic [XLEN:0]   nxt_hi,
  output logic [XLEN-1:0] nxt_lo
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    sum     = acc_hi + (acc_lo[0] ? {1'b0, opb} : '0);
    shifted = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opb};
    nxt_hi  = '0;
    nxt_lo  = '0;
    if (is_div) begin
      // Remainder stays below the divisor, so its top bit is always free for the shift.
      if (!diff[XLEN+1]) begin
        nxt_hi = diff[XLEN:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = shifted;
        nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      nxt_hi = {1'b0, sum[XLEN:1]};
      nxt_lo = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit, radix-2^BPC, valid/ready in and out, kill on flush.
// Optional: define MULDIV_ZERO_SKIP_EN to send multiplies with a zero operand down the fast path.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kill,
  output logic        is_muldiv,
  output logic        busy,
  muldiv_seq_if.slave bus
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N);

  md_state_e       state, state_nx;
  muldiv_op_e      op, f3_op;
  logic [2:0]      op_bits;
  logic [XLEN:0]   acc_hi, nxt_hi;
  logic [XLEN-1:0] acc_lo, nxt_lo, opb;
  logic            neg_res;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] result_q;

  logic            accept, last, fast, div_zero, div_ovf, zero_mul;
  logic            is_div_in, sgn1, sgn2, neg1, neg2, neg_in;
  logic [XLEN-1:0] mag1, mag2, fast_result, final_result, div_sel;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign is_muldiv     = decode_muldiv(bus.opcode, bus.funct7_m);
  assign bus.in_ready  = (state == MD_IDLE) && !reset;
  assign bus.out_valid = (state == MD_DONE);
  assign bus.result    = result_q;
  assign busy          = (state != MD_IDLE);
  assign accept        = bus.in_valid && bus.in_ready && is_muldiv && !kill;
  assign last          = (state == MD_BUSY) && (cnt == CW'(N - 1));
  assign op_bits       = op;

  // Operand decode: magnitudes, result sign and special cases.
  always_comb begin
    f3_op     = muldiv_op_e'(bus.funct3);
    is_div_in = bus.funct3[2];
    sgn1      = (f3_op == FNC_MULH) || (f3_op == FNC_MULHSU) ||
                (f3_op == FNC_DIV)  || (f3_op == FNC_REM);
    sgn2      = (f3_op == FNC_MULH) || (f3_op == FNC_DIV) || (f3_op == FNC_REM);
    neg1      = sgn1 && bus.rs1[XLEN-1];
    neg2      = sgn2 && bus.rs2[XLEN-1];
    mag1      = neg1 ? -bus.rs1 : bus.rs1;
    mag2      = neg2 ? -bus.rs2 : bus.rs2;
    neg_in    = (is_div_in && bus.funct3[1]) ? neg1 : (neg1 ^ neg2);
    div_zero  = is_div_in && (bus.rs2 == '0);
    div_ovf   = ((f3_op == FNC_DIV) || (f3_op == FNC_REM)) &&
                (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
`ifdef MULDIV_ZERO_SKIP_EN
    zero_mul  = !is_div_in && ((bus.rs1 == '0) || (bus.rs2 == '0));
`else
    zero_mul  = 1'b0;
`endif
    fast      = div_zero || div_ovf || zero_mul;
    if (div_zero)     fast_result = bus.funct3[1] ? bus.rs1 : '1;
    else if (div_ovf) fast_result = bus.funct3[1] ? '0 : bus.rs1;
    else              fast_result = '0;
  end

  for (genvar g = 0; g < BPC; g++) begin : g_step
    logic [XLEN:0]   stage_hi_in, stage_hi;
    logic [XLEN-1:0] stage_lo_in, stage_lo;
    if (g == 0) begin : g_first
      assign stage_hi_in = acc_hi;
      assign stage_lo_in = acc_lo;
    end else begin : g_next
      assign stage_hi_in = g_step[g-1].stage_hi;
      assign stage_lo_in = g_step[g-1].stage_lo;
    end
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (op_bits[2]),
      .opb    (opb),
      .acc_hi (stage_hi_in),
      .acc_lo (stage_lo_in),
      .nxt_hi (stage_hi),
      .nxt_lo (stage_lo)
    );
  end

  assign nxt_hi = g_step[BPC-1].stage_hi;
  assign nxt_lo = g_step[BPC-1].stage_lo;

  always_comb begin
    prod     = {nxt_hi[XLEN-1:0], nxt_lo};
    prod_fix = neg_res ? -prod : prod;
    div_sel  = op_bits[1] ? nxt_hi[XLEN-1:0] : nxt_lo;
    if (op_bits[2])          final_result = neg_res ? -div_sel : div_sel;
    else if (op == FNC_MUL)  final_result = prod_fix[XLEN-1:0];
    else                     final_result = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      MD_IDLE: if (accept)        state_nx = fast ? MD_DONE : MD_BUSY;
      MD_BUSY: if (last)          state_nx = MD_DONE;
      MD_DONE: if (bus.out_ready) state_nx = MD_IDLE;
      default:                    state_nx = MD_IDLE;
    endcase
    if (kill) state_nx = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      op       <= FNC_MUL;
      neg_res  <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else if (accept) begin
      op      <= f3_op;
      neg_res <= neg_in;
      acc_hi  <= '0;
      acc_lo  <= is_div_in ? mag1 : mag2;
      opb     <= is_div_in ? mag2 : mag1;
      cnt     <= '0;
      if (fast) result_q <= fast_result;
    end else if ((state == MD_BUSY) && !kill) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt + 1'b1;
      if (last) result_q <= final_result;
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequential RV32M/RV64M multiply/divide execute unit, sitting beside the ALU in the execute stage.
- Decodes opcode/funct3/funct7[0] into a multiply or divide operation.
- Runs an iterative radix-2^BPC datapath and returns the result over a valid/ready handshake.
- The pipeline stalls on in_ready/out_valid; kill aborts on flush.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- BPC, 1, bits retired per iteration; must be 1, 2 or 4; iterations N = XLEN/BPC.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  unit can accept; = (state==IDLE) && !reset.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7_m  in  1  instruction[25]; 1 selects the M extension.
- rs1  in  XLEN  dividend / multiplicand.
- rs2  in  XLEN  divisor / multiplier.
- kill  in  1  abort any in-flight op (pipeline flush).
- is_muldiv  out  1  combinational: opcode==OPC_ARI_RTYPE && funct7_m; the hazard unit uses it.
- busy  out  1  state != IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  final result.

Behaviour:
- Accept: in_valid && in_ready && is_muldiv && !kill. Non-M ops are never accepted and leave the state unchanged.
- Captured op by funct3:
  - 000 MUL (low XLEN bits).
  - 001 MULH (s×s high).
  - 010 MULHSU (s×u high).
  - 011 MULHU (u×u high).
  - 100 DIV.
  - 101 DIVU.
  - 110 REM.
  - 111 REMU.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - On accept, register the operand magnitudes (abs for signed variants), the result-sign flags and the op, then go to BUSY with the iteration counter at 0.
  - Fast path: from IDLE, go directly to DONE with the result registered, skipping BUSY, for these special cases:
    - Divide by zero: quotient = all ones; remainder = rs1.
    - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones, DIV/REM): quotient = rs1; remainder = 0.
- BUSY:
  - Each cycle retires BPC shift-add (mul) or restoring-subtract (div) steps and increments the counter.
  - When the counter reaches N-1, apply sign correction and register result; go to DONE.
  - Sign rules: quotient is negative iff operand signs differ; remainder takes the dividend's sign; the MULH* product is negated if its sign flag is set.
- DONE: out_valid=1; result held stable until out_ready; on out_ready go to IDLE.
  - in_ready rises the cycle after the handshake; no back-to-back accept in the same cycle as out handshake.
- Latency from the accept edge:
  - Normal: out_valid at T+N+1.
  - Fast path: out_valid at T+1.
- Kill:
  - Any state -> IDLE next cycle; out_valid drops; result keeps its last value.
  - Kill beats accept in the same cycle; kill beats out_ready in DONE (result discarded).
- Reset values: state IDLE, out_valid 0, busy 0, result 0, counter 0; in_ready 0 while reset is high, 1 the cycle after.
- Reset mid-operation behaves as kill plus clearing result.
- Internal product register 2*XLEN wide; divider remainder XLEN+1 wide; no truncation before the final select.

Optional Feature:
- MULDIV_ZERO_SKIP_EN:
  - Defined: a multiply whose rs1 or rs2 is zero takes the fast path (result 0, out_valid at T+1).
  - Undefined: zero operands iterate normally (T+N+1). Results are identical either way.

Decomposition:
- Shared header MulDivop.vh, next to ALUop.vh and Opcode.vh:
  - `FNC7_MULDIV.
  - `FNC_MUL .. `FNC_REMU funct3 constants.
  - State encodings MD_IDLE/MD_BUSY/MD_DONE.
- One natural sub-module, muldiv_step: combinational single radix-2 step (mul shift-add or div restoring subtract), instantiated BPC times in a chain inside muldiv_seq.

Test Plan (XLEN=32, BPC=1 unless noted):
- MUL: rs1=7, rs2=0xFFFFFFFD, accept at T -> out_valid at T+33, result=0xFFFFFFEB; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV/REM signed: rs1=0xFFFFFFF9 (-7), rs2=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF. REMU 17,5 -> 2. Repeat with BPC=4: out_valid at T+9.
- Special cases:
  - DIVU x/0 with rs1=0x1234 -> 0xFFFFFFFF at T+1; REMU -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: out_ready low 5 cycles after out_valid -> result stable, in_ready=0, busy=1; on out_ready, in_ready=1 the next cycle.
- Kill at iteration 10 -> out_valid never asserts, in_ready=1 next cycle; a following MUL 3×4 returns 12.
- Non-M op (opcode ARI_RTYPE, funct7_m=0, in_valid=1) -> is_muldiv=0, state stays IDLE, out_valid stays 0.
